// File: rtl/lsu_pkg.sv
// Shared LSU definitions: clog2 helper, default tag-pool size and tag-index type.
package lsu_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    localparam int LSUQ_SIZE = 4;

    typedef logic [clog2(LSUQ_SIZE)-1:0] lsu_tag_t;

endpackage

// File: rtl/lsu_lowest_set_encoder.sv
// Priority encoder: index of the lowest set bit of an N-bit vector, plus a valid flag.
module lsu_lowest_set_encoder
    import lsu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        in_bits,
    output logic [clog2(N)-1:0] index,
    output logic                valid
);

    localparam int W = clog2(N);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_bits[i]) begin
                index = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsu_index_buffer.sv
// Tag-indexed metadata store: allocates the lowest free slot, reads by tag, frees on release.
// Define LSU_INDEX_BUFFER_CHECKS_EN to enable simulation-only misuse checks.
module lsu_index_buffer
    import lsu_pkg::*;
#(
    parameter int DATAW = 8,
    parameter int SIZE  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [clog2(SIZE)-1:0]    write_addr,
    input  logic                      acquire_slot,
    input  logic [DATAW-1:0]          write_data,
    input  logic [clog2(SIZE)-1:0]    read_addr,
    output logic [DATAW-1:0]          read_data,
    input  logic [clog2(SIZE)-1:0]    release_addr,
    input  logic                      release_slot,
    output logic                      full,
    output logic                      empty
);

    localparam int ADDRW = clog2(SIZE);

    logic [SIZE-1:0]  free_mask;
    logic [SIZE-1:0]  free_n;
    logic [SIZE-1:0]  acq_onehot;
    logic [SIZE-1:0]  rel_onehot;
    logic [ADDRW-1:0] lowest_free;
    logic             any_free;
    logic             do_acquire;
    logic [DATAW-1:0] records [SIZE];

    assign do_acquire = acquire_slot && !full;

    // Decoding by equality drops out-of-range release indices naturally.
    always_comb begin
        acq_onehot = '0;
        rel_onehot = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (do_acquire && (write_addr == ADDRW'(i))) begin
                acq_onehot[i] = 1'b1;
            end
            if (release_slot && (release_addr == ADDRW'(i))) begin
                rel_onehot[i] = 1'b1;
            end
        end
    end

    // Release is OR-ed in last so it wins over a same-index acquire.
    assign free_n = (free_mask & ~acq_onehot) | rel_onehot;

    lsu_lowest_set_encoder #(
        .N (SIZE)
    ) u_encoder (
        .in_bits (free_n),
        .index   (lowest_free),
        .valid   (any_free)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            free_mask  <= {SIZE{1'b1}};
            write_addr <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
        end else begin
            free_mask  <= free_n;
            write_addr <= lowest_free;
            full       <= !any_free;
            empty      <= (free_n == {SIZE{1'b1}});
        end
    end

    always_ff @(posedge clk) begin
        if (do_acquire && !reset) begin
            records[write_addr] <= write_data;
        end
    end

    assign read_data = records[read_addr];

`ifdef LSU_INDEX_BUFFER_CHECKS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (acquire_slot && full) begin
                $error("%0t: acquire while full (write_addr=%0d)", $time, write_addr);
            end
            if (release_slot && (32'(release_addr) < SIZE) && free_mask[release_addr]) begin
                $error("%0t: release of free slot %0d", $time, release_addr);
            end
            if ((32'(read_addr) < SIZE) && free_mask[read_addr]) begin
                $error("%0t: read of free slot %0d", $time, read_addr);
            end
        end
    end
`else
    // Checks compiled out; functional behaviour is unchanged.
`endif

endmodule

// File: tb/tb_lsu_index_buffer.sv
// Self-checking bench for lsu_index_buffer: directed test plan followed by randomized traffic.
module tb_lsu_index_buffer;

    localparam int DATAW = 8;
    localparam int SIZE  = 4;
    localparam int ADDRW = 2;

    logic             clk;
    logic             reset;
    logic [ADDRW-1:0] write_addr;
    logic             acquire_slot;
    logic [DATAW-1:0] write_data;
    logic [ADDRW-1:0] read_addr;
    logic [DATAW-1:0] read_data;
    logic [ADDRW-1:0] release_addr;
    logic             release_slot;
    logic             full;
    logic             empty;

    int checks = 0;
    int errors = 0;

    // Reference model: slot occupancy and stored records as plain arrays.
    bit       m_used    [SIZE];
    bit       m_written [SIZE];
    int       m_rec     [SIZE];
    int       m_wa;
    bit       m_full;
    bit       m_empty;

    lsu_index_buffer #(
        .DATAW (DATAW),
        .SIZE  (SIZE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_addr   (write_addr),
        .acquire_slot (acquire_slot),
        .write_data   (write_data),
        .read_addr    (read_addr),
        .read_data    (read_data),
        .release_addr (release_addr),
        .release_slot (release_slot),
        .full         (full),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_refresh();
        int n_free;
        n_free = 0;
        m_wa = -1;
        for (int i = 0; i < SIZE; i++) begin
            if (!m_used[i]) begin
                n_free++;
                if (m_wa < 0) m_wa = i;
            end
        end
        if (m_wa < 0) m_wa = 0;
        m_full  = (n_free == 0);
        m_empty = (n_free == SIZE);
    endtask

    task automatic model_reset();
        for (int i = 0; i < SIZE; i++) begin
            m_used[i]    = 0;
            m_written[i] = 0;
        end
        model_refresh();
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".write_addr"}, 32'(write_addr), 32'(m_wa));
        chk({tag, ".full"}, 32'(full), 32'(m_full));
        chk({tag, ".empty"}, 32'(empty), 32'(m_empty));
    endtask

    // One clock: drive inputs, advance the model at the edge, check registered outputs.
    task automatic do_cycle(input string tag, input bit acq, input int wdata,
                            input bit rel, input int raddr);
        int slot;
        acquire_slot = acq;
        write_data   = DATAW'(wdata);
        release_slot = rel;
        release_addr = ADDRW'(raddr);
        @(posedge clk);
        if (acq && !m_full) begin
            slot = m_wa;
            m_used[slot]    = 1;
            m_written[slot] = 1;
            m_rec[slot]     = wdata;
        end
        if (rel && raddr < SIZE) m_used[raddr] = 0;
        model_refresh();
        #1;
        acquire_slot = 1'b0;
        release_slot = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
        check_state(tag);
    endtask

    task automatic check_read(input string tag, input int addr, input int exp);
        read_addr = ADDRW'(addr);
        #1;
        chk(tag, 32'(read_data), 32'(exp));
    endtask

    initial begin
        reset        = 1'b1;
        acquire_slot = 1'b0;
        write_data   = '0;
        read_addr    = '0;
        release_addr = '0;
        release_slot = 1'b0;

        // Reset then idle.
        do_reset("reset");
        do_cycle("idle", 0, 0, 0, 0);
        chk("idle.empty_const", 32'(empty), 32'd1);

        // Fill all four slots.
        for (int k = 0; k < 4; k++) begin
            chk("fill.wa_before", 32'(write_addr), 32'(k));
            do_cycle("fill", 1, 'hA0 + k, 0, 0);
        end
        chk("fill.full_const", 32'(full), 32'd1);
        check_read("fill.read2", 2, 'hA2);

        // Acquire while full is ignored.
        do_cycle("full_acq", 1, 'hFF, 0, 0);
        for (int k = 0; k < 4; k++) check_read("full_acq.read", k, 'hA0 + k);

        // Release slot 1, then refill it.
        do_cycle("rel1", 0, 0, 1, 1);
        chk("rel1.full_const", 32'(full), 32'd0);
        chk("rel1.wa_const", 32'(write_addr), 32'd1);
        do_cycle("acq_b1", 1, 'hB1, 0, 0);
        check_read("acq_b1.read1", 1, 'hB1);
        chk("acq_b1.full_const", 32'(full), 32'd1);

        // Free slots 0 and 3, then acquire slot 0 while releasing 3.
        do_cycle("rel0", 0, 0, 1, 0);
        do_cycle("rel3", 0, 0, 1, 3);
        chk("rel03.wa_const", 32'(write_addr), 32'd0);
        do_cycle("acq_rel3", 1, 'hC0, 1, 3);
        chk("acq_rel3.wa_const", 32'(write_addr), 32'd3);
        check_read("acq_rel3.read0", 0, 'hC0);

        // Acquire and release of the same index: release wins.
        do_cycle("rel2", 0, 0, 1, 2);
        chk("rel2.wa_const", 32'(write_addr), 32'd2);
        do_cycle("same2", 1, 'hD2, 1, 2);
        chk("same2.wa_const", 32'(write_addr), 32'd2);
        chk("same2.full_const", 32'(full), 32'd0);

        // Reset mid-sequence.
        do_reset("mid_reset");
        chk("mid_reset.wa_const", 32'(write_addr), 32'd0);
        chk("mid_reset.empty_const", 32'(empty), 32'd1);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r == 0) begin
                do_reset("rand_reset");
            end else begin
                do_cycle("rand", ($urandom_range(0, 99) < 55), $urandom_range(0, 255),
                         ($urandom_range(0, 99) < 40), $urandom_range(0, SIZE - 1));
                for (int s = 0; s < SIZE; s++) begin
                    if (m_written[s]) check_read("rand.read", s, m_rec[s]);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
